mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit instruction opcode and sequences the datapath through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and write enable.
- Produces the 3-bit ALUOp consumed by the ALU control decoder, so it is the issuing end of the ALUOp interface.

Parameters:
- OPW, 6, opcode width.
- STW, 4, state register width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH.
- mem_ready  in  1  memory handshake; a memory state completes only in a cycle where this is 1.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write qualified by ALU zero (datapath ANDs).
- IorD  out  1  0=PC address, 1=ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  1=MDR to register file.
- RegDst  out  1  1=rd, 0=rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0=PC, 1=register A.
- ALUSrcB  out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALUOp  out  3  000 add, 001 sub, 010 use funct, 100 addi, 101 andi, 110 ori.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- state  out  4  current state, for debug.
- illegal_op  out  1  high in DECODE when opcode is unsupported.

Behaviour:
- Moore FSM: one state register; all outputs decode from state (plus opcode/mem_ready where noted). No registered output delay.
- Reset (rst_n=0, async):
  - state=FETCH(0).
  - Every output is forced to 0 while rst_n=0.
  - First fetch begins on the first rising edge after release.
  - Reset asserted mid-instruction aborts it immediately: no further write enable is asserted.
- Any output not listed for a state is 0.
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101.
- FETCH(0):
  - Outputs: MemRead=1, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE(1):
  - Outputs: ALUSrcB=11, ALUOp=000.
  - Next state: R -> EXEC_R; lw/sw -> MEMADR; beq -> BEQ; j -> JUMP; addi/andi/ori -> IMM_EX.
  - Any other opcode: illegal_op=1 and next state FETCH.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD(3): MemRead=1, IorD=1. Wait for mem_ready, then MEMWB.
- MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR(5): MemWrite=1, IorD=1. Wait for mem_ready, then FETCH.
- EXEC_R(6): ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next ALUWB.
- ALUWB(7): RegWrite=1, RegDst=1. Next FETCH.
- BEQ(8): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01. Next FETCH.
- IMM_EX(9):
  - Outputs: ALUSrcA=1, ALUSrcB=10.
  - ALUOp is 100 for addi, 101 for andi, 110 for ori (decoded from opcode).
  - Next IMM_WB.
- IMM_WB(10): RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- JUMP(11): PCWrite=1, PCSource=10. Next FETCH.
- Codes 12-15 are unreachable. If entered, they behave as FETCH-next with all outputs 0.
- Latency, with mem_ready tied to 1, in cycles FETCH-to-FETCH:
  - R=4, lw=5, sw=4, beq=3, j=3, imm=4, illegal=2.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- While waiting, outputs hold their values and no write enable pulses.
- MemRead and MemWrite are never both 1.
- RegWrite, PCWrite and IRWrite are each high for at most one cycle per wait-completion.

Test Plan:
- Reset: rst_n=0 mid-MEMWB (RegWrite=1) -> all outputs drop to 0 the same cycle, state=0. After release with mem_ready=1, the first cycle has MemRead=1, IRWrite=1, PCWrite=1.
- R-type, opcode=000000, mem_ready=1 -> state sequence 0,1,6,7,0. ALUOp=010 in state 6. RegWrite=1 and RegDst=1 in state 7 only.
- lw, opcode=100011, mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0. IorD=1 and MemRead=1 throughout state 3. MemtoReg=1 and RegWrite=1 in state 4.
- sw then beq then j -> sw: 0,1,2,5,0 with MemWrite=1 only in 5. beq: 0,1,8,0 with ALUOp=001, PCWriteCond=1, PCSource=01. j: 0,1,11,0 with PCWrite=1, PCSource=10.
- addi/andi/ori (001000/001100/001101) -> state 9 outputs ALUOp 100/101/110 respectively. State 10 has RegWrite=1, RegDst=0.
- Illegal opcode 111111 -> illegal_op=1 for exactly the DECODE cycle, next state 0, no RegWrite/MemWrite asserted. mem_ready=0 held for 3 cycles in FETCH -> state stays 0 and IRWrite stays 0 until mem_ready rises.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle for the multicycle MIPS controller.
// The controller is the master: it consumes opcode/mem_ready and drives every select and enable.
interface mips_multicycle_control_if #(
    parameter int unsigned OPW = 6,
    parameter int unsigned STW = 4
);
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           PCWrite;
    logic           PCWriteCond;
    logic           IorD;
    logic           MemRead;
    logic           MemWrite;
    logic           IRWrite;
    logic           MemtoReg;
    logic           RegDst;
    logic           RegWrite;
    logic           ALUSrcA;
    logic [1:0]     ALUSrcB;
    logic [2:0]     ALUOp;
    logic [1:0]     PCSource;
    logic [STW-1:0] state;
    logic           illegal_op;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main Moore control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and decodes every datapath select, write enable and the ALUOp code.
module mips_multicycle_control #(
    parameter int unsigned OPW = 6,
    parameter int unsigned STW = 4
) (
    input logic                        clk,
    input logic                        rst_n,
    mips_multicycle_control_if.master  bus
);
    localparam logic [STW-1:0] FETCH  = 4'd0;
    localparam logic [STW-1:0] DECODE = 4'd1;
    localparam logic [STW-1:0] MEMADR = 4'd2;
    localparam logic [STW-1:0] MEMRD  = 4'd3;
    localparam logic [STW-1:0] MEMWB  = 4'd4;
    localparam logic [STW-1:0] MEMWR  = 4'd5;
    localparam logic [STW-1:0] EXEC_R = 4'd6;
    localparam logic [STW-1:0] ALUWB  = 4'd7;
    localparam logic [STW-1:0] BEQ    = 4'd8;
    localparam logic [STW-1:0] IMM_EX = 4'd9;
    localparam logic [STW-1:0] IMM_WB = 4'd10;
    localparam logic [STW-1:0] JUMP   = 4'd11;

    localparam logic [OPW-1:0] OP_R    = 6'b000000;
    localparam logic [OPW-1:0] OP_LW   = 6'b100011;
    localparam logic [OPW-1:0] OP_SW   = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPW-1:0] OP_J    = 6'b000010;
    localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
    localparam logic [OPW-1:0] OP_ANDI = 6'b001100;
    localparam logic [OPW-1:0] OP_ORI  = 6'b001101;

    logic [STW-1:0] state_q, state_d;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                state_d   = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_R:                     state_d = EXEC_R;
                    OP_LW, OP_SW:             state_d = MEMADR;
                    OP_BEQ:                   state_d = BEQ;
                    OP_J:                     state_d = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = IMM_EX;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (bus.opcode == OP_LW) begin
                    state_d = MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = MEMWR;
                end
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = bus.mem_ready ? FETCH : MEMWR;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = IMM_WB;
                case (bus.opcode)
                    OP_ADDI: alu_op = 3'b100;
                    OP_ANDI: alu_op = 3'b101;
                    OP_ORI:  alu_op = 3'b110;
                    default: alu_op = 3'b000;
                endcase
            end
            IMM_WB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset gates every output combinationally so an aborted instruction writes nothing.
    assign bus.PCWrite     = rst_n & pc_write;
    assign bus.PCWriteCond = rst_n & pc_write_cond;
    assign bus.IorD        = rst_n & i_or_d;
    assign bus.MemRead     = rst_n & mem_read;
    assign bus.MemWrite    = rst_n & mem_write;
    assign bus.IRWrite     = rst_n & ir_write;
    assign bus.MemtoReg    = rst_n & mem_to_reg;
    assign bus.RegDst      = rst_n & reg_dst;
    assign bus.RegWrite    = rst_n & reg_write;
    assign bus.ALUSrcA     = rst_n & alu_src_a;
    assign bus.ALUSrcB     = rst_n ? alu_src_b : 2'b00;
    assign bus.ALUOp       = rst_n ? alu_op : 3'b000;
    assign bus.PCSource    = rst_n ? pc_source : 2'b00;
    assign bus.illegal_op  = rst_n & illegal;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control: walks each instruction class
// cycle by cycle and compares state plus the full output bundle against a spec-table model.
module tb_mips_multicycle_control;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mips_multicycle_control_if #(.OPW(6), .STW(4)) ifc ();

    mips_multicycle_control #(.OPW(6), .STW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {ifc.PCWrite, ifc.PCWriteCond, ifc.IorD, ifc.MemRead, ifc.MemWrite,
                  ifc.IRWrite, ifc.MemtoReg, ifc.RegDst, ifc.RegWrite, ifc.ALUSrcA,
                  ifc.ALUSrcB, ifc.ALUOp, ifc.PCSource, ifc.illegal_op};

    // Expected output bundle straight from the per-state output table.
    function automatic logic [17:0] exp_outs(input int st, input logic [5:0] op, input logic mr);
        logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
        logic [1:0] srcb, pcs;
        logic [2:0] aop;
        {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = '0;
        srcb = 2'b00; pcs = 2'b00; aop = 3'b000;
        case (st)
            0: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1: begin
                srcb = 2'b11;
                ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                        op == 6'b000100 || op == 6'b000010 || op == 6'b001000 ||
                        op == 6'b001100 || op == 6'b001101);
            end
            2: begin srca = 1; srcb = 2'b10; end
            3: begin mrd = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mwr = 1; iord = 1; end
            6: begin srca = 1; aop = 3'b010; end
            7: begin rw = 1; rdst = 1; end
            8: begin srca = 1; aop = 3'b001; pcc = 1; pcs = 2'b01; end
            9: begin
                srca = 1; srcb = 2'b10;
                aop = (op == 6'b001000) ? 3'b100 : (op == 6'b001100) ? 3'b101 : 3'b110;
            end
            10: rw = 1;
            11: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ifc.mem_ready = 1'b0; ifc.opcode = 6'b000000;
        #3;
        checks++;
        if (obs !== 18'd0 || ifc.state !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold outs=%h state=%0d want outs=0 state=0", obs, ifc.state);
        end
        next_cycle();
        rst_n = 1'b1; ifc.mem_ready = 1'b1;
        #1;
        checks++;
        if (ifc.MemRead !== 1'b1 || ifc.IRWrite !== 1'b1 || ifc.PCWrite !== 1'b1 ||
            ifc.state !== 4'd0) begin
            errors++;
            $display("FAIL reset_release MemRead=%b IRWrite=%b PCWrite=%b state=%0d want 1 1 1 0",
                     ifc.MemRead, ifc.IRWrite, ifc.PCWrite, ifc.state);
        end
    endtask

    task automatic test_rtype();
        int st[4] = '{0, 1, 6, 7};
        ifc.opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            ifc.mem_ready = 1'b1; #1;
            checks++;
            if (ifc.state !== st[i][3:0]) begin
                errors++;
                $display("FAIL rtype_state cyc=%0d got %0d want %0d", i, ifc.state, st[i]);
            end
            checks++;
            if (obs !== exp_outs(st[i], ifc.opcode, 1'b1)) begin
                errors++;
                $display("FAIL rtype_outs cyc=%0d got %h want %h", i, obs,
                         exp_outs(st[i], ifc.opcode, 1'b1));
            end
            next_cycle();
        end
    endtask

    task automatic test_lw();
        int   st[7] = '{0, 1, 2, 3, 3, 3, 4};
        logic mr[7] = '{1, 1, 1, 0, 0, 1, 1};
        ifc.opcode = 6'b100011;
        for (int i = 0; i < 7; i++) begin
            ifc.mem_ready = mr[i]; #1;
            checks++;
            if (ifc.state !== st[i][3:0]) begin
                errors++;
                $display("FAIL lw_state cyc=%0d got %0d want %0d", i, ifc.state, st[i]);
            end
            checks++;
            if (obs !== exp_outs(st[i], ifc.opcode, mr[i])) begin
                errors++;
                $display("FAIL lw_outs cyc=%0d got %h want %h", i, obs,
                         exp_outs(st[i], ifc.opcode, mr[i]));
            end
            next_cycle();
        end
    endtask

    task automatic test_sw_beq_j();
        int         st[10] = '{0, 1, 2, 5, 0, 1, 8, 0, 1, 11};
        logic [5:0] op[10];
        op = '{6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b000100, 6'b000100, 6'b000100,
               6'b000010, 6'b000010, 6'b000010};
        for (int i = 0; i < 10; i++) begin
            ifc.opcode = op[i]; ifc.mem_ready = 1'b1; #1;
            checks++;
            if (ifc.state !== st[i][3:0]) begin
                errors++;
                $display("FAIL swbeqj_state cyc=%0d got %0d want %0d", i, ifc.state, st[i]);
            end
            checks++;
            if (obs !== exp_outs(st[i], op[i], 1'b1)) begin
                errors++;
                $display("FAIL swbeqj_outs cyc=%0d got %h want %h", i, obs,
                         exp_outs(st[i], op[i], 1'b1));
            end
            next_cycle();
        end
    endtask

    task automatic test_imm();
        logic [5:0] ops[3];
        logic [2:0] aops[3];
        int         st[4] = '{0, 1, 9, 10};
        ops  = '{6'b001000, 6'b001100, 6'b001101};
        aops = '{3'b100, 3'b101, 3'b110};
        for (int k = 0; k < 3; k++) begin
            ifc.opcode = ops[k];
            for (int i = 0; i < 4; i++) begin
                ifc.mem_ready = 1'b1; #1;
                checks++;
                if (ifc.state !== st[i][3:0] || obs !== exp_outs(st[i], ops[k], 1'b1)) begin
                    errors++;
                    $display("FAIL imm_outs op=%b cyc=%0d state=%0d outs=%h want state=%0d outs=%h",
                             ops[k], i, ifc.state, obs, st[i], exp_outs(st[i], ops[k], 1'b1));
                end
                if (i == 2) begin
                    checks++;
                    if (ifc.ALUOp !== aops[k]) begin
                        errors++;
                        $display("FAIL imm_aluop op=%b got %b want %b", ops[k], ifc.ALUOp,
                                 aops[k]);
                    end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_illegal_wait();
        int   st[6] = '{0, 0, 0, 0, 1, 0};
        logic mr[6] = '{0, 0, 0, 1, 1, 0};
        ifc.opcode = 6'b111111;
        for (int i = 0; i < 6; i++) begin
            ifc.mem_ready = mr[i]; #1;
            checks++;
            if (ifc.state !== st[i][3:0]) begin
                errors++;
                $display("FAIL illegal_state cyc=%0d got %0d want %0d", i, ifc.state, st[i]);
            end
            checks++;
            if (obs !== exp_outs(st[i], ifc.opcode, mr[i])) begin
                errors++;
                $display("FAIL illegal_outs cyc=%0d got %h want %h", i, obs,
                         exp_outs(st[i], ifc.opcode, mr[i]));
            end
            checks++;
            if (ifc.illegal_op !== (st[i] == 1) || ifc.IRWrite !== (st[i] == 0 && mr[i])) begin
                errors++;
                $display("FAIL illegal_flags cyc=%0d illegal_op=%b IRWrite=%b", i,
                         ifc.illegal_op, ifc.IRWrite);
            end
            if (i < 5) next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        ifc.opcode = 6'b100011; ifc.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) next_cycle();
        checks++;
        if (ifc.state !== 4'd4 || ifc.RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre state=%0d RegWrite=%b want 4 1", ifc.state, ifc.RegWrite);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (obs !== 18'd0 || ifc.state !== 4'd0) begin
            errors++;
            $display("FAIL midrst_abort outs=%h state=%0d want 0 0", obs, ifc.state);
        end
        next_cycle();
        rst_n = 1'b1; #1;
        checks++;
        if (ifc.state !== 4'd0 || obs !== exp_outs(0, ifc.opcode, 1'b1)) begin
            errors++;
            $display("FAIL midrst_release state=%0d outs=%h want 0 %h", ifc.state, obs,
                     exp_outs(0, ifc.opcode, 1'b1));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rtype();
        test_lw();
        test_sw_beq_j();
        test_imm();
        test_illegal_wait();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
